// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature-controller ADC front end.
package temp_ctrl_pkg;
  localparam int ADC_BITS = 12;
  localparam logic [ADC_BITS-1:0] RAIL_LO = 12'h000;
  localparam logic [ADC_BITS-1:0] RAIL_HI = 12'hFFF;
  localparam logic [1:0] CMD_PREFIX = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } adc_state_e;

  // A reading pinned at either rail means an open or shorted sensor.
  function automatic logic is_rail(input logic [ADC_BITS-1:0] v);
    return (v == RAIL_LO) || (v == RAIL_HI);
  endfunction
endpackage

// File: rtl/moving_avg4.sv
// Four-tap moving average with a running sum; the first sample after reset
// fills the whole window so the output starts at that sample.
module moving_avg4
  import temp_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [ADC_BITS-1:0] sample,
  output logic [ADC_BITS-1:0] avg
);
  logic [ADC_BITS-1:0] hist [4];
  logic [ADC_BITS+1:0] sum_q;
  logic [ADC_BITS+1:0] sum_n;
  logic                filled;

  always_comb begin
    if (filled) sum_n = sum_q - {2'b00, hist[3]} + {2'b00, sample};
    else        sum_n = {sample, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '{default: '0};
      sum_q  <= '0;
      filled <= 1'b0;
      avg    <= '0;
    end else if (push) begin
      if (filled) begin
        hist[0] <= sample;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
      end else begin
        for (int i = 0; i < 4; i++) hist[i] <= sample;
      end
      sum_q  <= sum_n;
      filled <= 1'b1;
      avg    <= sum_n[ADC_BITS+1:2];
    end
  end
endmodule

// File: rtl/adc_spi_master.sv
// Periodic 16-SCLK SPI read of the 12-bit temperature ADC, with rail-fault
// screening and a 4-tap moving average on good samples.
module adc_spi_master
  import temp_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = 5,
  parameter int SAMPLE_PERIOD = 10000,
  parameter int CS_SETUP      = 2,
  parameter int CS_HOLD       = 2,
  parameter int FAULT_COUNT   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          channel,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic                adc_mosi,
  output logic [ADC_BITS-1:0] adc_raw,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_valid,
  output logic                sensor_fault,
  output logic                busy,
  output adc_state_e          fsm_state
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int CW = 16;
  localparam logic [TW-1:0] TMR_LAST   = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [7:0]    FAULT_MAX  = 8'(FAULT_COUNT);

  adc_state_e          state, state_n;
  logic [TW-1:0]       tmr;
  logic                tick;
  logic [CW-1:0]       cnt;
  logic                phase;      // 0: SCLK high half, 1: SCLK low half
  logic [4:0]          bit_cnt;    // SCLK falling edges seen this frame
  logic [3:0]          cmd_sr;
  logic [ADC_BITS-1:0] shreg;
  logic [7:0]          fcnt;
  logic [7:0]          fcnt_inc;
  logic                rail;
  logic                push;

  assign tick      = (tmr == TMR_LAST);
  assign rail      = is_rail(shreg);
  assign push      = (state == ST_DONE) && !rail;
  assign fcnt_inc  = (fcnt < FAULT_MAX) ? fcnt + 8'd1 : fcnt;
  assign busy      = (state != ST_IDLE) || adc_valid;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    adc_mosi = 1'b0;
    case (state)
      ST_IDLE:  if (tick && enable) state_n = ST_SETUP;
      ST_SETUP: begin
        adc_cs_n = 1'b0;
        adc_mosi = cmd_sr[3];
        if (cnt == SETUP_LAST) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = ~phase;
        adc_mosi = cmd_sr[3];
        if (cnt == DIV_LAST && phase && bit_cnt == 5'd16) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        adc_cs_n = 1'b0;
        if (cnt == HOLD_LAST) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Timer preloads to its last count so the first tick lands right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr     <= TMR_LAST;
      cnt     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      cmd_sr  <= '0;
      shreg   <= '0;
    end else begin
      tmr <= tick ? '0 : tmr + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          phase   <= 1'b0;
          bit_cnt <= '0;
          if (state_n == ST_SETUP) cmd_sr <= {CMD_PREFIX, channel};
        end
        ST_SETUP: cnt <= (cnt == SETUP_LAST) ? '0 : cnt + 1'b1;
        ST_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
            if (!phase) begin
              bit_cnt <= bit_cnt + 5'd1;
              cmd_sr  <= {cmd_sr[2:0], 1'b0};
            end else if (bit_cnt >= 5'd4 && bit_cnt <= 5'd15) begin
              // Rising edges 5..16 carry the result, MSB first.
              shreg <= {shreg[ADC_BITS-2:0], adc_miso};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: cnt <= (cnt == HOLD_LAST) ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_raw      <= '0;
      adc_valid    <= 1'b0;
      sensor_fault <= 1'b0;
      fcnt         <= '0;
    end else begin
      adc_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        adc_raw <= shreg;
        if (rail) begin
          fcnt         <= fcnt_inc;
          sensor_fault <= (fcnt_inc == FAULT_MAX);
        end else begin
          fcnt         <= '0;
          sensor_fault <= 1'b0;
        end
      end
    end
  end

  moving_avg4 u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .sample (shreg),
    .avg    (adc_data)
  );
endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: default-timing instance plus a minimum-timing
// instance, each with an SPI ADC model and a valid-driven scoreboard.
module tb_adc_spi_master;
  import temp_ctrl_pkg::*;

  localparam int SP        = 400;
  localparam int SP_M      = 40;
  localparam int FRAME_LEN = 2 + 32 * 5 + 2;
  localparam int FRAME_M   = 1 + 32 * 1 + 1;
  localparam logic [3:0] MOSI_M = {CMD_PREFIX, 2'b01};
  localparam int EW = 30;

  typedef struct packed {
    logic [11:0] raw;
    logic [11:0] data;
    logic        fault;
    logic [3:0]  mosi;
    logic        chk_int;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // main instance
  logic        enable, adc_miso, adc_sclk, adc_cs_n, adc_mosi;
  logic [1:0]  channel;
  logic [11:0] adc_raw, adc_data;
  logic        adc_valid, sensor_fault, busy;
  adc_state_e  fsm_state;

  adc_spi_master #(.SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .channel(channel),
    .adc_miso(adc_miso), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n),
    .adc_mosi(adc_mosi), .adc_raw(adc_raw), .adc_data(adc_data),
    .adc_valid(adc_valid), .sensor_fault(sensor_fault), .busy(busy),
    .fsm_state(fsm_state)
  );

  // minimum-timing instance
  logic        enable_m, miso_m, sclk_m, cs_n_m, mosi_m;
  logic [11:0] raw_m, data_m;
  logic        valid_m, fault_m, busy_m;
  adc_state_e  state_m;

  adc_spi_master #(.CLK_DIV(1), .SAMPLE_PERIOD(SP_M), .CS_SETUP(1), .CS_HOLD(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .enable(enable_m), .channel(2'b01),
    .adc_miso(miso_m), .adc_sclk(sclk_m), .adc_cs_n(cs_n_m),
    .adc_mosi(mosi_m), .adc_raw(raw_m), .adc_data(data_m),
    .adc_valid(valid_m), .sensor_fault(fault_m), .busy(busy_m),
    .fsm_state(state_m)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [11:0]   exp_m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC models: MISO shifts on SCLK falls, MOSI captured on SCLK rises
  logic [11:0] adc_value = '0;
  logic [15:0] fw = '0;
  int          bit_idx = 0, rises = 0;
  logic [3:0]  mosi_seen = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  always @(adc_cs_n or adc_sclk) begin
    if (prev_cs && !adc_cs_n) begin
      fw = {4'b0000, adc_value}; bit_idx = 15; adc_miso = fw[15];
      rises = 0; mosi_seen = '0;
    end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
      if (bit_idx > 0) bit_idx--;
      adc_miso = fw[bit_idx];
    end else if (!adc_cs_n && !prev_sclk && adc_sclk) begin
      rises++;
      if (rises <= 4) mosi_seen = {mosi_seen[2:0], adc_mosi};
    end
    prev_cs = adc_cs_n; prev_sclk = adc_sclk;
  end

  logic [15:0] fw_m = {4'b0000, 12'hA5A};
  int          idx_m = 0, rises_m = 0;
  logic [3:0]  mseen_m = '0;
  logic        pcs_m = 1'b1, psclk_m = 1'b0;
  always @(cs_n_m or sclk_m) begin
    if (pcs_m && !cs_n_m) begin
      idx_m = 15; miso_m = fw_m[15]; rises_m = 0; mseen_m = '0;
    end else if (!cs_n_m && psclk_m && !sclk_m) begin
      if (idx_m > 0) idx_m--;
      miso_m = fw_m[idx_m];
    end else if (!cs_n_m && !psclk_m && sclk_m) begin
      rises_m++;
      if (rises_m <= 4) mseen_m = {mseen_m[2:0], mosi_m};
    end
    pcs_m = cs_n_m; psclk_m = sclk_m;
  end

  // scoreboard monitor, main instance
  int   low_cnt = 0, last_len = 0, last_valid_cyc = 0;
  logic prev_valid = 1'b0, have_last = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 0; prev_valid = 1'b0; have_last = 1'b0;
    end else begin
      if (!adc_cs_n) low_cnt++;
      else if (low_cnt != 0) begin last_len = low_cnt; low_cnt = 0; end
      if (prev_valid) begin
        check("valid_width", 32'(adc_valid), 32'd0);
        check("busy_after_valid", 32'(busy), 32'd0);
      end
      if (adc_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_valid: got raw 0x%0h with empty expected queue", adc_raw);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("adc_raw", 32'(adc_raw), 32'(e.raw));
          check("adc_data", 32'(adc_data), 32'(e.data));
          check("sensor_fault", 32'(sensor_fault), 32'(e.fault));
          check("mosi_cmd", 32'(mosi_seen), 32'(e.mosi));
          check("sclk_rises", rises, 32'd16);
          check("cs_low_len", last_len, FRAME_LEN);
          check("busy_in_valid", 32'(busy), 32'd1);
          if (e.chk_int && have_last) check("valid_interval", cyc - last_valid_cyc, SP);
        end
        last_valid_cyc = cyc; have_last = 1'b1;
      end
      prev_valid = adc_valid;
    end
  end

  // scoreboard monitor, minimum-timing instance
  int          low_m = 0, len_m = 0;
  logic [11:0] em;
  always @(negedge clk) begin
    if (!rst_n) low_m = 0;
    else begin
      if (!cs_n_m) low_m++;
      else if (low_m != 0) begin len_m = low_m; low_m = 0; end
      if (valid_m) begin
        if (exp_m_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL min_unexpected_valid: got raw 0x%0h with empty expected queue", raw_m);
        end else begin
          em = exp_m_q.pop_front();
          check("min_raw", 32'(raw_m), 32'(em));
          check("min_data", 32'(data_m), 32'(em));
          check("min_cs_low_len", len_m, FRAME_M);
          check("min_sclk_rises", rises_m, 32'd16);
          check("min_mosi_cmd", 32'(mseen_m), 32'(MOSI_M));
        end
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic [11:0] raw, input logic [11:0] data,
                          input logic fault, input logic chk);
    exp_t x;
    x.raw = raw; x.data = data; x.fault = fault;
    x.mosi = {CMD_PREFIX, channel}; x.chk_int = chk;
    exp_q.push_back(EW'(x));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!adc_valid && n < 2 * SP + 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!adc_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: no adc_valid within %0d cycles", name, n);
    end
    @(negedge clk);
  endtask

  task automatic wait_cs_fall(input string name);
    int n = 0;
    while (adc_cs_n && n < 2 * SP) begin @(negedge clk); n++; end
    check({name, "_cs_fall"}, 32'(adc_cs_n), 32'd0);
  endtask

  task automatic frame(input logic [11:0] v, input logic [11:0] data,
                       input logic fault, input logic chk);
    adc_value = v;
    push_exp(v, data, fault, chk);
    wait_valid("frame");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs_n"}, 32'(adc_cs_n), 32'd1);
    check({tag, "_sclk"}, 32'(adc_sclk), 32'd0);
    check({tag, "_mosi"}, 32'(adc_mosi), 32'd0);
    check({tag, "_raw"}, 32'(adc_raw), 32'd0);
    check({tag, "_data"}, 32'(adc_data), 32'd0);
    check({tag, "_valid"}, 32'(adc_valid), 32'd0);
    check({tag, "_fault"}, 32'(sensor_fault), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  // minimum-timing stimulus: three frames of 0xA5A, then stop
  initial begin
    int n = 0;
    enable_m = 1'b1;
    repeat (3) exp_m_q.push_back(12'hA5A);
    while (exp_m_q.size() != 0 && n < 20 * SP_M) begin @(negedge clk); n++; end
    check("min_frames_done", exp_m_q.size(), 32'd0);
    enable_m = 1'b0;
  end

  // main stimulus
  initial begin
    int saw_fall = 0;
    enable = 1'b0; channel = 2'b00; adc_value = '0;
    repeat (4) @(negedge clk);
    check_reset_values("reset");

    // steady 2252 on channel 0; first frame starts one clock after release
    enable = 1'b1;
    adc_value = 12'd2252;
    push_exp(12'd2252, 12'd2252, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_cs_fall", 32'(adc_cs_n), 32'd0);
    check("first_mosi", 32'(adc_mosi), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    wait_valid("steady0");
    frame(12'd2252, 12'd2252, 1'b0, 1'b1);
    frame(12'd2252, 12'd2252, 1'b0, 1'b1);

    // 2048 on channel 2 washes the window, then step to 2457
    channel = 2'b10;
    frame(12'd2048, 12'd2201, 1'b0, 1'b1);
    frame(12'd2048, 12'd2150, 1'b0, 1'b1);
    frame(12'd2048, 12'd2099, 1'b0, 1'b1);
    frame(12'd2048, 12'd2048, 1'b0, 1'b1);
    channel = 2'b00;
    frame(12'd2457, 12'd2150, 1'b0, 1'b1);
    frame(12'd2457, 12'd2252, 1'b0, 1'b1);
    frame(12'd2457, 12'd2354, 1'b0, 1'b1);
    frame(12'd2457, 12'd2457, 1'b0, 1'b1);

    // top-rail fault: asserts on the third reading, data holds
    frame(12'hFFF, 12'd2457, 1'b0, 1'b1);
    frame(12'hFFF, 12'd2457, 1'b0, 1'b1);
    frame(12'hFFF, 12'd2457, 1'b1, 1'b1);
    frame(12'd2048, 12'd2354, 1'b0, 1'b1);

    // enable drops mid-SHIFT: frame completes, then no new frames
    adc_value = 12'd2048;
    push_exp(12'd2048, 12'd2252, 1'b0, 1'b1);
    wait_cs_fall("endrop");
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_valid("endrop");
    repeat (2 * SP) begin
      @(negedge clk);
      if (!adc_cs_n) saw_fall++;
    end
    check("no_frame_while_disabled", saw_fall, 32'd0);
    enable = 1'b1;
    frame(12'd3000, 12'd2388, 1'b0, 1'b0);

    // reset in the middle of SHIFT
    adc_value = 12'd1500;
    wait_cs_fall("midreset");
    repeat (60) @(negedge clk);
    check("pre_reset_sclk_active", 32'(fsm_state), 32'(ST_SHIFT));
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clk);
    adc_value = 12'd1000;
    push_exp(12'd1000, 12'd1000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_cs_fall", 32'(adc_cs_n), 32'd0);
    wait_valid("restart");

    // bottom rail is screened, then a good sample averages with the prefill
    frame(12'h000, 12'd1000, 1'b0, 1'b1);
    frame(12'd1200, 12'd1050, 1'b0, 1'b1);

    check("exp_queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
